// File: rtl/simd_comm_net_pkg.sv
// rtl/simd_comm_net_pkg.sv - opcodes, default sizes and latency helper for simd_comm_net
// Shared by simd_comm_net and simd_reduce_tree.
package simd_comm_net_pkg;

   localparam int NPROC_DEF = 4;
   localparam int WIDTH_DEF = 16;
   localparam int OP_W      = 3;

   typedef enum logic [OP_W-1:0] {
      OP_LEFT  = 3'd0,
      OP_RIGHT = 3'd1,
      OP_GOR   = 3'd2,
      OP_GAND  = 3'd3,
      OP_GSUM  = 3'd4,
      OP_BCAST = 3'd5
   } op_e;

   // One registered tree level per log2(nproc) plus the output register.
   function automatic int lat_f(input int nproc);
      return $clog2(nproc) + 1;
   endfunction

   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return op <= OP_BCAST;
   endfunction

   function automatic logic op_reduce(input logic [OP_W-1:0] op);
      return (op == OP_GOR) || (op == OP_GAND) || (op == OP_GSUM);
   endfunction

endpackage

// File: rtl/simd_reduce_tree.sv
// rtl/simd_reduce_tree.sv - registered binary reduction tree (OR / AND / SUM) over enabled lanes
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   i_hold       freeze every level (downstream stall)
//   i_op         operation select, travels down the tree with its data
//   i_en         lane enable mask; disabled lanes feed the identity value
//   i_data       packed lane words
//   o_root       reduction result, log2(NPROC) cycles after input
//   o_op         operation that belongs to o_root
module simd_reduce_tree
   import simd_comm_net_pkg::*;
#(
   parameter int NPROC = NPROC_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_hold,
   input  logic [OP_W-1:0]        i_op,
   input  logic [NPROC-1:0]       i_en,
   input  logic [NPROC*WIDTH-1:0] i_data,
   output logic [WIDTH-1:0]       o_root,
   output logic [OP_W-1:0]        o_op
);

   localparam int LVL = $clog2(NPROC);

   function automatic logic [WIDTH-1:0] ident(input logic [OP_W-1:0] op);
      return (op == OP_GAND) ? '1 : '0;
   endfunction

   function automatic logic [WIDTH-1:0] comb2(input logic [OP_W-1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (op)
         OP_GOR:  return a | b;
         OP_GAND: return a & b;
         OP_GSUM: return a + b;
         default: return '0;
      endcase
   endfunction

   logic [NPROC*WIDTH-1:0] w_leaf;

   for (genvar i = 0; i < NPROC; i++) begin : g_leaf
      assign w_leaf[i*WIDTH +: WIDTH] = i_en[i] ? i_data[i*WIDTH +: WIDTH] : ident(i_op);
   end

   for (genvar l = 1; l <= LVL; l++) begin : g_lvl
      localparam int NW = NPROC >> l;
      logic [2*NW*WIDTH-1:0] w_kid;
      logic [OP_W-1:0]       w_op;
      logic [NW*WIDTH-1:0]   w_nxt;
      logic [NW*WIDTH-1:0]   r_q;
      logic [OP_W-1:0]       r_op;

      if (l == 1) begin : g_src
         assign w_kid = w_leaf;
         assign w_op  = i_op;
      end else begin : g_src
         assign w_kid = g_lvl[l-1].r_q;
         assign w_op  = g_lvl[l-1].r_op;
      end

      for (genvar j = 0; j < NW; j++) begin : g_node
         assign w_nxt[j*WIDTH +: WIDTH] = comb2(w_op, w_kid[2*j*WIDTH +: WIDTH],
                                                w_kid[(2*j+1)*WIDTH +: WIDTH]);
      end

      always_ff @(posedge clk) begin
         if (!reset) begin
            r_q  <= '0;
            r_op <= '0;
         end else if (!i_hold) begin
            r_q  <= w_nxt;
            r_op <= w_op;
         end
      end
   end

   assign o_root = g_lvl[LVL].r_q;
   assign o_op   = g_lvl[LVL].r_op;

endmodule

// File: rtl/simd_comm_net.sv
// rtl/simd_comm_net.sv - SIMD lane communication network: shifts, reductions, broadcast
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   in_valid / in_ready   operation handshake (in_ready = !stall)
//   op, src, en, data_in  operation, broadcast source, lane mask, packed lane words
//   out_valid / out_ready result handshake
//   data_out, err         packed per-lane result, illegal-op flag
module simd_comm_net
   import simd_comm_net_pkg::*;
#(
   parameter int NPROC = NPROC_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OP_W-1:0]          op,
   input  logic [$clog2(NPROC)-1:0] src,
   input  logic [NPROC-1:0]         en,
   input  logic [NPROC*WIDTH-1:0]   data_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NPROC*WIDTH-1:0]   data_out,
   output logic                     err
);

   localparam int LAT = lat_f(NPROC);
   localparam int LVL = LAT - 1;
   localparam int DW  = NPROC * WIDTH;

   logic                 w_stall;
   logic [WIDTH-1:0]     w_lane [NPROC];
   logic [DW-1:0]        w_perm;
   logic [WIDTH-1:0]     w_root;
   logic [OP_W-1:0]      w_op_out;
   logic                 w_ok;
   logic                 w_red;
   logic                 w_err;
   logic [DW-1:0]        w_res;

   logic                 r_vld  [1:LVL];
   logic [NPROC-1:0]     r_en   [1:LVL];
   logic [DW-1:0]        r_lane [1:LVL];
   logic                 r_out_valid;
   logic [DW-1:0]        r_data_out;
   logic                 r_err;

   assign w_stall  = r_out_valid && !out_ready;
   assign in_ready = !w_stall;

   // Shifts and broadcast are resolved at the input; the words then ride
   // alongside the tree so every op sees the same latency.
   for (genvar i = 0; i < NPROC; i++) begin : g_perm
      assign w_lane[i] = data_in[i*WIDTH +: WIDTH];
      assign w_perm[i*WIDTH +: WIDTH] =
         (op == OP_LEFT)  ? w_lane[(i + NPROC - 1) % NPROC] :
         (op == OP_RIGHT) ? w_lane[(i + 1) % NPROC] :
         (op == OP_BCAST) ? w_lane[src] : w_lane[i];
   end

   simd_reduce_tree #(
      .NPROC (NPROC),
      .WIDTH (WIDTH)
   ) u_tree (
      .clk    (clk),
      .reset  (reset),
      .i_hold (w_stall),
      .i_op   (op),
      .i_en   (en),
      .i_data (data_in),
      .o_root (w_root),
      .o_op   (w_op_out)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 1; k <= LVL; k++) begin
            r_vld[k]  <= 1'b0;
            r_en[k]   <= '0;
            r_lane[k] <= '0;
         end
      end else if (!w_stall) begin
         r_vld[1]  <= in_valid;
         r_en[1]   <= en;
         r_lane[1] <= w_perm;
         for (int k = 2; k <= LVL; k++) begin
            r_vld[k]  <= r_vld[k-1];
            r_en[k]   <= r_en[k-1];
            r_lane[k] <= r_lane[k-1];
         end
      end
   end

   // The op for the final stage comes out of the tree, which carries it level by level.
   assign w_ok  = r_vld[LVL] && op_legal(w_op_out);
   assign w_red = op_reduce(w_op_out);
   assign w_err = r_vld[LVL] && !op_legal(w_op_out);

   for (genvar i = 0; i < NPROC; i++) begin : g_res
      assign w_res[i*WIDTH +: WIDTH] = (w_ok && r_en[LVL][i]) ?
         (w_red ? w_root : r_lane[LVL][i*WIDTH +: WIDTH]) : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_data_out  <= '0;
         r_err       <= 1'b0;
      end else if (!w_stall) begin
         r_out_valid <= r_vld[LVL];
         r_data_out  <= w_res;
         r_err       <= w_err;
      end
   end

   assign out_valid = r_out_valid;
   assign data_out  = r_data_out;
   assign err       = r_err;

endmodule

// File: tb/tb_simd_comm_net.sv
// tb/tb_simd_comm_net.sv - self-checking bench for simd_comm_net (NPROC=4, WIDTH=16)
module tb_simd_comm_net;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int LAT = 3;

   logic            clk;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [1:0]      src;
   logic [N-1:0]    en;
   logic [N*W-1:0]  data_in;
   logic            out_valid;
   logic            out_ready;
   logic [N*W-1:0]  data_out;
   logic            err;

   int n_err = 0;
   int n_chk = 0;

   simd_comm_net #(.NPROC(N), .WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src       (src),
      .en        (en),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: results straight from the operation definitions.
   function automatic logic [N*W-1:0] model_fn(input logic [2:0] o, input logic [1:0] s,
                                                input logic [N-1:0] e, input logic [N*W-1:0] d,
                                                output logic er);
      logic [W-1:0]   ln  [N];
      logic [W-1:0]   res [N];
      logic [W-1:0]   acc;
      int             sum;
      logic [N*W-1:0] out;
      for (int i = 0; i < N; i++) begin
         ln[i]  = d[i*W +: W];
         res[i] = '0;
      end
      er  = 1'b0;
      acc = '0;
      sum = 0;
      case (o)
         3'd0: for (int i = 0; i < N; i++) res[i] = ln[(i + N - 1) % N];
         3'd1: for (int i = 0; i < N; i++) res[i] = ln[(i + 1) % N];
         3'd2: begin
            for (int i = 0; i < N; i++) if (e[i]) acc = acc | ln[i];
            for (int i = 0; i < N; i++) res[i] = acc;
         end
         3'd3: begin
            acc = '1;
            for (int i = 0; i < N; i++) if (e[i]) acc = acc & ln[i];
            for (int i = 0; i < N; i++) res[i] = acc;
         end
         3'd4: begin
            for (int i = 0; i < N; i++) if (e[i]) sum = sum + int'(ln[i]);
            acc = W'(sum % 65536);
            for (int i = 0; i < N; i++) res[i] = acc;
         end
         3'd5: for (int i = 0; i < N; i++) res[i] = ln[s];
         default: er = 1'b1;
      endcase
      for (int i = 0; i < N; i++) out[i*W +: W] = (e[i] && !er) ? res[i] : '0;
      return out;
   endfunction

   // Scoreboard: each accepted op ages one step per non-stalled edge and is
   // due at the output once it has aged LAT steps.
   logic [N*W-1:0] q_data [$];
   logic           q_err  [$];
   int             q_age  [$];
   int             drained = 0;
   logic           armed   = 1'b0;

   always @(negedge clk) begin
      logic           exp_v;
      logic           stall;
      logic           er;
      logic [N*W-1:0] md;
      exp_v = 1'b0;
      if (q_age.size() > 0) exp_v = (q_age[0] == LAT);
      if (armed) begin
         chk("in_ready", 64'(in_ready), 64'(!(exp_v && !out_ready)));
         chk("out_valid", 64'(out_valid), 64'(exp_v));
         if (exp_v) begin
            chk("data_out", data_out, q_data[0]);
            chk("err", 64'(err), 64'(q_err[0]));
         end else begin
            chk("idle_data", data_out, 64'd0);
            chk("idle_err", 64'(err), 64'd0);
         end
      end
      if (!reset) begin
         q_data.delete();
         q_err.delete();
         q_age.delete();
         armed = 1'b1;
      end else if (armed) begin
         stall = exp_v && !out_ready;
         if (!stall) begin
            if (exp_v) begin
               void'(q_data.pop_front());
               void'(q_err.pop_front());
               void'(q_age.pop_front());
               drained++;
            end
            for (int k = 0; k < q_age.size(); k++) q_age[k] = q_age[k] + 1;
            if (in_valid) begin
               md = model_fn(op, src, en, data_in, er);
               q_data.push_back(md);
               q_err.push_back(er);
               q_age.push_back(1);
            end
         end
      end
   end

   // Single op into an empty pipeline; pins the exact latency and a literal result.
   task automatic dir(input string name, input logic [2:0] o, input logic [1:0] s,
                      input logic [N-1:0] e, input logic [N*W-1:0] d,
                      input logic [N*W-1:0] exp_d, input logic exp_e);
      in_valid = 1'b1; op = o; src = s; en = e; data_in = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (LAT - 2) @(posedge clk);
      @(negedge clk);
      chk({name, "_early"}, 64'(out_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk({name, "_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_data"}, data_out, exp_d);
      chk({name, "_err"}, 64'(err), 64'(exp_e));
      @(posedge clk); #1;
   endtask

   logic saw_low;

   task automatic send(input logic [2:0] o, input logic [N-1:0] e, input logic [N*W-1:0] d);
      logic acc;
      int   tries;
      in_valid = 1'b1; op = o; src = 2'd0; en = e; data_in = d;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         @(negedge clk);
         acc = in_ready;
         if (!in_ready) saw_low = 1'b1;
         @(posedge clk); #1;
         tries++;
      end
      in_valid = 1'b0;
      chk("send_accepted", 64'(acc), 64'd1);
   endtask

   initial begin
      int d0;
      int waited;
      reset = 1'b0; in_valid = 1'b0; op = '0; src = '0; en = '0; data_in = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_data", data_out, 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      dir("left",  3'd0, 2'd0, 4'b1111, 64'h0004_0003_0002_0001, 64'h0003_0002_0001_0004, 1'b0);
      dir("right", 3'd1, 2'd0, 4'b1111, 64'h0004_0003_0002_0001, 64'h0001_0004_0003_0002, 1'b0);
      dir("gsum",  3'd4, 2'd0, 4'b0111, 64'h0009_0005_0002_FFFF, 64'h0000_0006_0006_0006, 1'b0);
      dir("gand0", 3'd3, 2'd0, 4'b0000, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0);
      dir("bcast", 3'd5, 2'd2, 4'b1111, 64'h000D_000C_000B_000A, 64'h000C_000C_000C_000C, 1'b0);
      dir("gor",   3'd2, 2'd0, 4'b1011, 64'h0100_8000_0010_0001, 64'h0111_0000_0111_0111, 1'b0);
      dir("ill7",  3'd7, 2'd0, 4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);

      // Reset one cycle after accepting a GOR: that result must never appear.
      in_valid = 1'b1; op = 3'd2; en = 4'b1111; data_in = 64'h0001_0002_0004_0008;
      @(posedge clk); #1;
      in_valid = 1'b0; reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("flushed_no_valid", 64'(out_valid), 64'd0);
      end
      @(posedge clk); #1;

      // Six back-to-back ops with the consumer stalling for three cycles.
      saw_low = 1'b0;
      d0 = drained;
      fork
         begin
            for (int k = 0; k < 6; k++)
               send(3'($urandom_range(0, 5)), 4'($urandom), {$urandom, $urandom});
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      waited = 0;
      while (q_age.size() > 0 && waited < 30) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("stall_seen", 64'(saw_low), 64'd1);
      chk("stall_six_drained", 64'(drained - d0), 64'd6);

      // Randomised traffic with consumer back-pressure and occasional resets.
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom % 3) != 0;
         op        = (($urandom % 10) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
         src       = 2'($urandom);
         en        = 4'($urandom);
         data_in   = (($urandom % 4) == 0) ? {4{16'hFFFF}} : {$urandom, $urandom};
         out_ready = ($urandom % 4) != 0;
         reset     = ($urandom % 80) != 0;
         @(posedge clk); #1;
      end

      in_valid = 1'b0; out_ready = 1'b1; reset = 1'b1;
      waited = 0;
      while (q_age.size() > 0 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("final_drain_empty", 64'(q_age.size()), 64'd0);
      @(negedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
